// File: rtl/lsu.sv
// ============================================================================
// Module   : lsu
// Brief    : Memory-stage load/store unit. Issues one valid/ready bus
//            transaction per M-stage access, stalls via busy_M, returns the
//            aligned and extended load result.
//            Optional macro LSU_TIMEOUT_EN adds a REQ-wait abort with bus_err_M.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re_M,
    input  logic              we_M,
    input  logic [2:0]        funct3_M,
    input  logic [ADDR_W-1:0] addr_M,
    input  logic [31:0]       wdata_M,
    output logic              busy_M,
    output logic [31:0]       rdata_M,
    output logic              misaligned_M,
    output logic              bus_err_M,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_err_q, bus_err_d;

    logic        w_is_half;
    logic        w_is_word;
    logic        w_misaligned;
    logic        w_op;
    logic        w_valid;
    logic        w_busy;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_val;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign w_is_half    = (funct3_M[1:0] == 2'b01);
    assign w_is_word    = (funct3_M[1:0] == 2'b10);
    assign w_misaligned = (w_is_half & addr_M[0]) | (w_is_word & (addr_M[1:0] != 2'b00));
    assign misaligned_M = (re_M | we_M) & w_misaligned;
    assign w_op         = (re_M | we_M) & ~w_misaligned;

    assign mem_addr  = {addr_M[ADDR_W-1:2], 2'b00};
    assign mem_we    = we_M;

    always_comb begin
        mem_wstrb = 4'b0000;
        mem_wdata = wdata_M;
        if (we_M) begin
            case (funct3_M[1:0])
                2'b00: begin
                    mem_wstrb = 4'b0001 << addr_M[1:0];
                    mem_wdata = {4{wdata_M[7:0]}};
                end
                2'b01: begin
                    mem_wstrb = 4'b0011 << addr_M[1:0];
                    mem_wdata = {2{wdata_M[15:0]}};
                end
                default: begin
                    mem_wstrb = 4'b1111;
                    mem_wdata = wdata_M;
                end
            endcase
        end
    end

    always_comb begin
        w_byte = mem_rdata[7:0];
        case (addr_M[1:0])
            2'b00:   w_byte = mem_rdata[7:0];
            2'b01:   w_byte = mem_rdata[15:8];
            2'b10:   w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = addr_M[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_M[1:0])
            2'b00:   w_load_val = {{24{~funct3_M[2] & w_byte[7]}}, w_byte};
            2'b01:   w_load_val = {{16{~funct3_M[2] & w_half[15]}}, w_half};
            default: w_load_val = mem_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        bus_err_d = 1'b0;
        w_valid   = 1'b0;
        w_busy    = 1'b0;
`ifdef LSU_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_op) begin
                    w_valid = 1'b1;
                    w_busy  = 1'b1;
                    if (mem_ready) begin
                        state_d = S_DONE;
                        if (re_M) begin
                            rdata_d = w_load_val;
                        end
                    end else begin
                        state_d = S_REQ;
`ifdef LSU_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            S_REQ: begin
                w_valid = 1'b1;
                w_busy  = 1'b1;
                if (mem_ready) begin
                    state_d = S_DONE;
                    if (re_M) begin
                        rdata_d = w_load_val;
                    end
`ifdef LSU_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Last permitted wait cycle without a grant: abort.
                    state_d   = S_DONE;
                    bus_err_d = 1'b1;
                    rdata_d   = 32'h0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Gated by rst_n so an asserted reset drops the request without a clock edge.
    assign mem_valid = w_valid & rst_n;
    assign busy_M    = w_busy & rst_n;
    assign rdata_M   = rdata_q;
    assign bus_err_M = bus_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rdata_q   <= 32'h0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ============================================================================
// Module   : tb_lsu
// Brief    : Self-checking bench for lsu with a scoreboard of load results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        re_M = 1'b0;
    logic        we_M = 1'b0;
    logic [2:0]  funct3_M = 3'b000;
    logic [31:0] addr_M = 32'h0;
    logic [31:0] wdata_M = 32'h0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    logic        busy_M;
    logic [31:0] rdata_M;
    logic        misaligned_M;
    logic        bus_err_M;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_rdata = 32'h0;

    lsu #(
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (4)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .re_M         (re_M),
        .we_M         (we_M),
        .funct3_M     (funct3_M),
        .addr_M       (addr_M),
        .wdata_M      (wdata_M),
        .busy_M       (busy_M),
        .rdata_M      (rdata_M),
        .misaligned_M (misaligned_M),
        .bus_err_M    (bus_err_M),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One access; the memory grants after `waits` busy cycles.
    task automatic do_op(input logic re, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rword, input int waits,
                         input logic [31:0] exp_rdata, input logic [3:0] exp_strb,
                         input logic [31:0] exp_wdata);
        int          n;
        logic [31:0] res;
        @(negedge clk);
        re_M      = re;
        we_M      = we;
        funct3_M  = f3;
        addr_M    = addr;
        wdata_M   = wd;
        mem_rdata = rword;
        exp_q.push_back(re ? exp_rdata : model_rdata);
        n = 0;
        while (n < 64) begin
            mem_ready = (n == waits);
            #1;
            if (!busy_M) break;
            check("mem_valid_req", {31'b0, mem_valid}, 32'd1);
            check("mem_addr", mem_addr, {addr[31:2], 2'b00});
            check("mem_we", {31'b0, mem_we}, {31'b0, we});
            check("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, exp_strb});
            if (we) check("mem_wdata", mem_wdata, exp_wdata);
            n++;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        check("busy_cycles", n, waits + 1);
        res = exp_q.pop_front();
        check("rdata_M", rdata_M, res);
        check("done_valid", {31'b0, mem_valid}, 32'd0);
        check("done_bus_err", {31'b0, bus_err_M}, 32'd0);
        model_rdata = res;
        re_M = 1'b0;
        we_M = 1'b0;
    endtask

    task automatic mis_op(input logic re, input logic [2:0] f3, input logic [31:0] addr);
        @(negedge clk);
        re_M      = re;
        we_M      = ~re;
        funct3_M  = f3;
        addr_M    = addr;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("misaligned_M", {31'b0, misaligned_M}, 32'd1);
            check("mis_valid", {31'b0, mem_valid}, 32'd0);
            check("mis_busy", {31'b0, busy_M}, 32'd0);
            @(negedge clk);
        end
        re_M      = 1'b0;
        we_M      = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("mis_rdata", rdata_M, model_rdata);
    endtask

    initial begin
        #12;
        check("rst_busy", {31'b0, busy_M}, 32'd0);
        check("rst_valid", {31'b0, mem_valid}, 32'd0);
        check("rst_rdata", rdata_M, 32'h0);
        check("rst_bus_err", {31'b0, bus_err_M}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 4'b0000, 0);
        do_op(1, 0, 3'b000, 32'h103, 0, 32'h80FF1234, 3, 32'hFFFFFF80, 4'b0000, 0);
        do_op(1, 0, 3'b100, 32'h103, 0, 32'h80FF1234, 3, 32'h00000080, 4'b0000, 0);
        do_op(1, 0, 3'b001, 32'h102, 0, 32'h80FF1234, 1, 32'hFFFF80FF, 4'b0000, 0);
        do_op(1, 0, 3'b101, 32'h102, 0, 32'h80FF1234, 0, 32'h000080FF, 4'b0000, 0);
        do_op(1, 0, 3'b000, 32'h101, 0, 32'h80FF1234, 2, 32'h00000012, 4'b0000, 0);
        do_op(1, 0, 3'b001, 32'h100, 0, 32'h0000F00D, 0, 32'hFFFFF00D, 4'b0000, 0);
        do_op(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 0, 2, 0, 4'b1100, 32'hABCDABCD);
        do_op(0, 1, 3'b000, 32'h201, 32'h00000055, 0, 0, 0, 4'b0010, 32'h55555555);
        do_op(0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 0, 1, 0, 4'b1111, 32'hCAFEF00D);

        mis_op(1, 3'b010, 32'h101);
        mis_op(1, 3'b101, 32'h103);
        mis_op(0, 3'b010, 32'h302);

        // Back-to-back loads, reset asserted during REQ of the second.
        @(negedge clk);
        re_M      = 1'b1;
        funct3_M  = 3'b010;
        addr_M    = 32'h400;
        mem_rdata = 32'h11223344;
        mem_ready = 1'b1;
        #1;
        check("b2b_busy1", {31'b0, busy_M}, 32'd1);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("b2b_done_valid", {31'b0, mem_valid}, 32'd0);
        check("b2b_done_busy", {31'b0, busy_M}, 32'd0);
        check("b2b_rdata", rdata_M, 32'h11223344);
        addr_M    = 32'h404;
        mem_rdata = 32'h55667788;
        @(negedge clk);
        #1;
        check("b2b_second_issue", {31'b0, mem_valid}, 32'd1);
        @(negedge clk);
        #1;
        check("b2b_second_req", {31'b0, mem_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {31'b0, mem_valid}, 32'd0);
        check("rst_mid_busy", {31'b0, busy_M}, 32'd0);
        check("rst_mid_rdata", rdata_M, 32'h0);
        re_M = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_rdata = 32'h0;
        do_op(1, 0, 3'b010, 32'h500, 0, 32'h0BADC0DE, 0, 32'h0BADC0DE, 4'b0000, 0);

`ifdef LSU_TIMEOUT_EN
        begin
            int n;
            @(negedge clk);
            re_M      = 1'b1;
            funct3_M  = 3'b010;
            addr_M    = 32'h600;
            mem_ready = 1'b0;
            n = 0;
            while (n < 64) begin
                #1;
                if (!mem_valid) break;
                n++;
                @(negedge clk);
            end
            check("to_valid_cycles", n, 5);
            check("to_bus_err", {31'b0, bus_err_M}, 32'd1);
            check("to_busy", {31'b0, busy_M}, 32'd0);
            check("to_rdata", rdata_M, 32'h0);
            re_M = 1'b0;
            @(negedge clk);
            #1;
            check("to_bus_err_pulse", {31'b0, bus_err_M}, 32'd0);
            model_rdata = 32'h0;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lsu.md
Name: lsu

Overview:
- Memory-stage load/store unit: the producer of busy_M, which the hazard controller consumes to stall F/D/E/M and bubble W.
- Converts an M-stage load/store into a single valid/ready transaction on the data bus.
- Holds busy_M high until the transaction completes.
- Returns the aligned, sign/zero-extended load result.

Parameters:
- ADDR_W, 32, address width of addr_M and mem_addr.
- TIMEOUT_CYCLES, 255, cycles waiting for mem_ready before abort (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- re_M  in  1  M-stage instruction is a load.
- we_M  in  1  M-stage instruction is a store; re_M and we_M are never both 1.
- funct3_M  in  3  RV32 size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010.
- addr_M  in  ADDR_W  byte address.
- wdata_M  in  32  store data, right-aligned.
- busy_M  out  1  transaction outstanding; pipeline stalled.
- rdata_M  out  32  extended load result, valid in DONE.
- misaligned_M  out  1  access not naturally aligned; no bus transaction issued.
- bus_err_M  out  1  transaction aborted (LSU_TIMEOUT_EN only; tied 0 otherwise).
- mem_valid  out  1  request valid.
- mem_ready  in  1  request accepted; mem_rdata valid in the same cycle.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  word-aligned address, addr_M with bits [1:0] = 0.
- mem_wstrb  out  4  byte enables.
- mem_wdata  out  32  lane-shifted store data.
- mem_rdata  in  32  read word.

Behaviour:
- Reset (async, rst_n=0): state IDLE; rdata_M=0; bus_err_M=0; mem_valid=0; busy_M=0.
- Reset mid-transaction drops mem_valid immediately; the transaction is abandoned.
- States and transitions:
  - IDLE: op = (re_M|we_M) & ~misaligned_M. If op: go to REQ.
  - IDLE outputs: busy_M = op (combinational), mem_valid = op. A mem_ready in this same cycle completes the transaction → DONE, no REQ visit.
  - REQ: mem_valid=1, busy_M=1. mem_addr/mem_we/mem_wstrb/mem_wdata are held stable; inputs are stable because M is stalled. On mem_ready → DONE.
  - DONE: busy_M=0, mem_valid=0; rdata_M holds the captured value. The pipeline advances at the next edge. Next state is IDLE unconditionally.
  - A back-to-back memory op therefore starts in the cycle after DONE.
- Minimum cost: busy_M is high for at least 1 cycle per access. Total latency is 1 + wait cycles before DONE.
- Misalignment (combinational):
  - Condition: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠00.
  - Effect: misaligned_M=1, no request, busy_M=0, state stays IDLE.
- Store lanes:
  - SB: wstrb = 0001 << addr[1:0], wdata = {4{wdata_M[7:0]}}.
  - SH: wstrb = 0011 << addr[1:0], wdata = {2{wdata_M[15:0]}}.
  - SW: wstrb = 1111, wdata = wdata_M.
  - Loads: mem_wstrb = 0000.
- Load extraction:
  - Select the byte/half lane from mem_rdata using addr[1:0].
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - The result is registered on the handshake edge.
- Stores leave rdata_M unchanged.
- mem_valid never drops before mem_ready, except on reset or timeout abort.

Optional Feature:
LSU_TIMEOUT_EN
- Defined:
  - An 8+ bit counter clears on entry to REQ and increments each REQ cycle without mem_ready.
  - When it reaches TIMEOUT_CYCLES: drop mem_valid, go to DONE, pulse bus_err_M=1 for the DONE cycle, rdata_M=0.
  - mem_ready in the same cycle as expiry wins: normal completion, no error.
- Undefined: no counter; bus_err_M tied 0; REQ waits indefinitely.

Test Plan:
- LW addr=0x100, mem_ready high in the same cycle, mem_rdata=0xDEADBEEF → busy_M high exactly 1 cycle; next cycle rdata_M=0xDEADBEEF, busy_M=0.
- LB addr=0x103, mem_rdata=0x80FF1234 with 3 wait cycles → busy_M high 4 cycles; mem_addr=0x100 held stable; rdata_M=0xFFFFFF80. LBU with the same stimulus → 0x00000080.
- SH addr=0x202, wdata_M=0x0000ABCD → mem_we=1, mem_wstrb=1100, mem_wdata=0xABCDABCD, mem_addr=0x200.
- LW addr=0x101 → misaligned_M=1, mem_valid never asserts, busy_M=0.
- Two consecutive LW ops → transactions separated by exactly one DONE cycle; assert rst_n=0 during REQ of the second → mem_valid falls without a clock edge, state IDLE.
- (LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4) LW with mem_ready held 0 → mem_valid drops after 4 REQ cycles, bus_err_M=1 for one cycle, busy_M=0.
